// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential single-precision subtractor.
// Field widths are fixed to the IEEE-754 binary32 layout.
package fp_pkg;

    localparam int         EXP_W   = 8;
    localparam int         FRAC_W  = 23;
    localparam int         MANT_W  = 24;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADDSUB,
        NORM
    } fp_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_fields_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a binary32 word into sign, exponent and 24-bit mantissa.
// A zero exponent yields a zero mantissa, so denormals behave as signed zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] word_i,
    output fp_fields_t  fields_o
);

    always_comb begin
        fields_o.sign = word_i[31];
        fields_o.exp  = word_i[30:23];
        if (word_i[30:23] == 8'h00) begin
            fields_o.mant = '0;
        end else begin
            fields_o.mant = {1'b1, word_i[22:0]};
        end
    end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle binary32 subtractor dataR = dataA - dataB with a start/busy/done handshake.
// Alignment and normalisation shift one bit per clock to keep the datapath narrow.
module fp_subtractor_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] dataR,
    output logic        busy,
    output logic        done
);

    fp_state_t         state_q, state_d;
    logic [31:0]       opA_q, opA_d;
    logic [31:0]       opB_q, opB_d;
    logic [EXP_W-1:0]  expR_q, expR_d;
    logic [MANT_W-1:0] bigMant_q, bigMant_d;
    logic [MANT_W-1:0] smallMant_q, smallMant_d;
    logic              bigSign_q, bigSign_d;
    logic              smallSign_q, smallSign_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       dataR_q, dataR_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    fp_fields_t        fieldsA, fieldsB, fieldsBEff, opBig, opSmall;
    logic [EXP_W-1:0]  expDiff;
    logic [MANT_W:0]   sumAdd;
    logic [MANT_W-1:0] sumSub;

    fp_unpack u_unpackA (.word_i(opA_q), .fields_o(fieldsA));
    fp_unpack u_unpackB (.word_i(opB_q), .fields_o(fieldsB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            expR_q      <= '0;
            bigMant_q   <= '0;
            smallMant_q <= '0;
            bigSign_q   <= 1'b0;
            smallSign_q <= 1'b0;
            cnt_q       <= '0;
            dataR_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            expR_q      <= expR_d;
            bigMant_q   <= bigMant_d;
            smallMant_q <= smallMant_d;
            bigSign_q   <= bigSign_d;
            smallSign_q <= smallSign_d;
            cnt_q       <= cnt_d;
            dataR_q     <= dataR_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        expR_d      = expR_q;
        bigMant_d   = bigMant_q;
        smallMant_d = smallMant_q;
        bigSign_d   = bigSign_q;
        smallSign_d = smallSign_q;
        cnt_d       = cnt_q;
        dataR_d     = dataR_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        fieldsBEff      = fieldsB;
        fieldsBEff.sign = ~fieldsB.sign;
        if ({fieldsA.exp, fieldsA.mant} >= {fieldsB.exp, fieldsB.mant}) begin
            opBig   = fieldsA;
            opSmall = fieldsBEff;
        end else begin
            opBig   = fieldsBEff;
            opSmall = fieldsA;
        end
        expDiff = opBig.exp - opSmall.exp;
        sumAdd  = {1'b0, bigMant_q} + {1'b0, smallMant_q};
        sumSub  = bigMant_q - smallMant_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = dataA;
                    opB_d   = dataB;
                    busy_d  = 1'b1;
                    state_d = UNPACK;
                end
            end

            UNPACK: begin
                expR_d      = opBig.exp;
                bigMant_d   = opBig.mant;
                bigSign_d   = opBig.sign;
                smallSign_d = opSmall.sign;
                smallMant_d = (expDiff > 8'd24) ? '0 : opSmall.mant;
                cnt_d       = expDiff[4:0];
                if (expDiff >= 8'd1 && expDiff <= 8'd24) begin
                    state_d = ALIGN;
                end else begin
                    state_d = ADDSUB;
                end
            end

            ALIGN: begin
                smallMant_d = smallMant_q >> 1;
                cnt_d       = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ADDSUB;
                end
            end

            ADDSUB: begin
                if (bigSign_q == smallSign_q) begin
                    if (sumAdd[MANT_W]) begin
                        // A carry out of exponent 254 (or beyond) saturates to infinity.
                        if (expR_q >= 8'hFE) begin
                            expR_d    = EXP_MAX;
                            bigMant_d = {1'b1, {FRAC_W{1'b0}}};
                        end else begin
                            expR_d    = expR_q + 8'd1;
                            bigMant_d = sumAdd[MANT_W:1];
                        end
                    end else begin
                        bigMant_d = sumAdd[MANT_W-1:0];
                    end
                end else begin
                    bigMant_d = sumSub;
                    if (sumSub == '0) begin
                        bigSign_d = 1'b0;
                    end
                end
                state_d = NORM;
            end

            NORM: begin
                if (bigMant_q == '0 || bigMant_q[MANT_W-1] || expR_q <= 8'd1) begin
                    if (bigMant_q == '0) begin
                        dataR_d = 32'h0000_0000;
                    end else if (bigMant_q[MANT_W-1]) begin
                        dataR_d = {bigSign_q, expR_q, bigMant_q[FRAC_W-1:0]};
                    end else begin
                        dataR_d = {bigSign_q, 31'h0};
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    bigMant_d = bigMant_q << 1;
                    expR_d    = expR_q - 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign dataR = dataR_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
